regfile_16x32: RTL and testbench
================================

# regfile_16x32

Sixteen-entry, 32-bit general-purpose register file for the RISC datapath, sitting directly downstream of the 4:16 register-select decoder. It consumes the decoder's one-hot select lines as its write-port row enables and provides two synchronous read ports to the operand-fetch stage. It also checks that the write select is one-hot and flags violations.

## Interface
Parameters:
- WIDTH, 32, data width of each register
- DEPTH, 16, number of registers; fixed to match the one-hot select width

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst_n  input  1  asynchronous, active-low reset
- wr_en  input  1  write request qualifier
- wr_sel  input  16  one-hot write row select from the 4:16 decoder (bit i = register i)
- wr_data  input  32  write data
- rd_en  input  1  read request; read outputs update only when high
- rd_addr_a  input  4  read port A register index
- rd_addr_b  input  4  read port B register index
- rd_data_a  output  32  registered read data, port A
- rd_data_b  output  32  registered read data, port B
- rd_valid  output  1  high the cycle after an accepted read
- sel_error  output  1  one-cycle pulse: previous cycle had wr_en with a non-one-hot wr_sel

## Operation
- Reset (rst_n low, asynchronous): all 16 registers, rd_data_a, rd_data_b, rd_valid, sel_error cleared to 0; values hold until the first rising edge after rst_n goes high.
- Register 0 is hardwired zero: writes selecting bit 0 are discarded; reads of index 0 return 0.
- Write: on a rising edge with wr_en=1 and wr_sel having exactly one bit set at index i≠0, register i ← wr_data.
- Select check: wr_en=1 with wr_sel = 0 or with ≥2 bits set → no register is modified; sel_error=1 on the next cycle. wr_en=0 → wr_sel ignored, no error.
- Read: on a rising edge with rd_en=1, rd_data_a ← reg[rd_addr_a], rd_data_b ← reg[rd_addr_b], rd_valid ← 1. rd_en=0 → rd_data_a/b hold previous values, rd_valid ← 0.
- Both ports may address the same register; both return identical data.
- Same-edge write and read of the same register: governed by the configuration below.
- Reset asserted mid-operation clears all state immediately; a write in progress on that edge is lost.

## Timing
- Write latency: 1 cycle; data readable by a read issued on the following edge.
- Read latency: 1 cycle from rd_en edge to rd_data_a/b and rd_valid.
- sel_error: asserted exactly one cycle after the offending edge, deasserted the next cycle unless the violation repeats.
- No handshake back-pressure; reads and writes are accepted every cycle.

## Configuration
- REGFILE_BYPASS_EN defined: a read on the same edge as a valid write to the same non-zero register returns the new wr_data (write-through forwarding). Index 0 still returns 0; invalid-select writes are never forwarded.
- REGFILE_BYPASS_EN undefined: same-edge read returns the old register contents; new value visible one cycle later.

## Test plan
- Reset: write 0xDEADBEEF to r5, assert rst_n=0 mid-cycle → all outputs 0 immediately; read r5 after release → 0x00000000, rd_valid=1.
- Write/read all: write 0x1000_0000+i to r1..r15 via one-hot wr_sel, read pairs (i, 16-i) → matching values one cycle after rd_en; r0 write of 0xFFFFFFFF then read → 0.
- Bad select: wr_en=1, wr_sel=16'h0000 then 16'h0006 with wr_data=0xA5A5A5A5 → sel_error pulses one cycle each, r1/r2 unchanged.
- Same-edge conflict: r7=0x11111111, then write 0x22222222 to r7 while reading r7 on both ports → 0x22222222 with REGFILE_BYPASS_EN, 0x11111111 without; next read → 0x22222222 in both builds.
- Read hold: read r3=0x0000_0033, then rd_en=0 while r3 is rewritten to 0x44 → rd_data_a stays 0x33, rd_valid=0.

Source files
------------

// File: rtl/regfile_16x32.sv
// regfile_16x32: 16 x 32-bit register file with one-hot write row select,
// two registered read ports and a write-select sanity flag.
// Register 0 reads as zero and ignores writes.
// Optional build macro: REGFILE_BYPASS_EN.
//   Defined:   a read on the same edge as a valid write to the same register
//              returns the new write data.
//   Undefined: a same-edge read returns the old contents.
//
// Port timing: there is no back-pressure. A write (wr_en) and a read (rd_en)
// are each accepted on every rising edge where they are high.
// rd_valid marks the cycle after an accepted read. On that cycle,
// rd_data_a and rd_data_b carry the read result. When rd_en is low, both
// data outputs hold their last value.
module regfile_16x32 #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [DEPTH-1:0]         wr_sel,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  input  logic [$clog2(DEPTH)-1:0] rd_addr_a,
  input  logic [$clog2(DEPTH)-1:0] rd_addr_b,
  output logic [WIDTH-1:0]         rd_data_a,
  output logic [WIDTH-1:0]         rd_data_b,
  output logic                     rd_valid,
  output logic                     sel_error
);

  localparam logic [DEPTH-1:0] ONE = {{(DEPTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] regs [DEPTH];
  logic             sel_onehot;
  logic             wr_ok;
  logic [WIDTH-1:0] next_a;
  logic [WIDTH-1:0] next_b;

  // Decode the write select: exactly one bit set, and that bit is not row 0.
  always_comb begin
    sel_onehot = (wr_sel != '0) && ((wr_sel & (wr_sel - ONE)) == '0);
    wr_ok      = wr_en && sel_onehot && !wr_sel[0];
  end

  // Read-port data selection, with optional same-edge write forwarding.
  always_comb begin
    next_a = regs[rd_addr_a];
    next_b = regs[rd_addr_b];
`ifdef REGFILE_BYPASS_EN
    // wr_ok already excludes row 0, so index 0 is never forwarded.
    if (wr_ok && wr_sel[rd_addr_a]) next_a = wr_data;
    if (wr_ok && wr_sel[rd_addr_b]) next_b = wr_data;
`endif
  end

  // Register array: row 0 is held at zero; other rows load on a valid write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else begin
      for (int i = 1; i < DEPTH; i++) begin
        if (wr_ok && wr_sel[i]) regs[i] <= wr_data;
      end
    end
  end

  // Registered read ports: data holds and valid drops when no read is requested.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_a <= '0;
      rd_data_b <= '0;
      rd_valid  <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) begin
        rd_data_a <= next_a;
        rd_data_b <= next_b;
      end
    end
  end

  // One-cycle flag for a write request whose select is not one-hot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sel_error <= 1'b0;
    else        sel_error <= wr_en && !sel_onehot;
  end

endmodule

// File: tb/tb_regfile_16x32.sv
// Testbench for regfile_16x32.
// A behavioural array model tracks register contents and expected outputs.
// Every cycle, the outputs are compared against that model. Hand-computed
// literal expectations pin the directed scenarios.
module tb_regfile_16x32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        wr_en;
  logic [15:0] wr_sel;
  logic [31:0] wr_data;
  logic        rd_en;
  logic [3:0]  rd_addr_a;
  logic [3:0]  rd_addr_b;
  logic [31:0] rd_data_a;
  logic [31:0] rd_data_b;
  logic        rd_valid;
  logic        sel_error;

  regfile_16x32 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (wr_en),
    .wr_sel    (wr_sel),
    .wr_data   (wr_data),
    .rd_en     (rd_en),
    .rd_addr_a (rd_addr_a),
    .rd_addr_b (rd_addr_b),
    .rd_data_a (rd_data_a),
    .rd_data_b (rd_data_b),
    .rd_valid  (rd_valid),
    .sel_error (sel_error)
  );

  // ---------------- behavioural model ----------------
  logic [31:0] m_regs [16];
  logic [31:0] m_a;
  logic [31:0] m_b;
  logic        m_valid;
  logic        m_err;

  int errors = 0;
  int checks = 0;

  task automatic model_clear();
    for (int i = 0; i < 16; i++) m_regs[i] = 32'h0;
    m_a = 32'h0;
    m_b = 32'h0;
    m_valid = 1'b0;
    m_err = 1'b0;
  endtask

  // Apply one rising edge worth of behaviour from the current inputs.
  task automatic model_edge();
    int n;
    int idx;
    logic wvalid;
    if (!rst_n) begin
      model_clear();
      return;
    end
    n = $countones(wr_sel);
    idx = 0;
    for (int i = 0; i < 16; i++) if (wr_sel[i]) idx = i;
    wvalid = wr_en && (n == 1) && (idx != 0);
    if (rd_en) begin
      m_a = m_regs[rd_addr_a];
      m_b = m_regs[rd_addr_b];
`ifdef REGFILE_BYPASS_EN
      if (wvalid && int'(rd_addr_a) == idx) m_a = wr_data;
      if (wvalid && int'(rd_addr_b) == idx) m_b = wr_data;
`endif
      m_valid = 1'b1;
    end else begin
      m_valid = 1'b0;
    end
    m_err = wr_en && (n != 1);
    if (wvalid) m_regs[idx] = wr_data;
  endtask

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic compare_all();
    check("model_rd_data_a", rd_data_a, m_a);
    check("model_rd_data_b", rd_data_b, m_b);
    check("model_rd_valid", {31'h0, rd_valid}, {31'h0, m_valid});
    check("model_sel_error", {31'h0, sel_error}, {31'h0, m_err});
  endtask

  // One clock: the model follows the edge, then outputs are checked at negedge.
  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all();
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_idle();
    wr_en = 1'b0; wr_sel = 16'h0; wr_data = 32'h0;
    rd_en = 1'b0; rd_addr_a = 4'h0; rd_addr_b = 4'h0;
  endtask

  task automatic drive_write(input int idx, input logic [31:0] d);
    wr_en = 1'b1;
    wr_sel = 16'h1 << idx;
    wr_data = d;
  endtask

  task automatic drive_read(input int a, input int b);
    rd_en = 1'b1;
    rd_addr_a = 4'(a);
    rd_addr_b = 4'(b);
  endtask

  // ---------------- stimulus ----------------
  logic [31:0] conflict_exp;

  initial begin
    rst_n = 1'b0;
    drive_idle();
    model_clear();
    @(negedge clk);
    check("reset_rd_data_a", rd_data_a, 32'h0);
    check("reset_rd_data_b", rd_data_b, 32'h0);
    check("reset_rd_valid", {31'h0, rd_valid}, 32'h0);
    check("reset_sel_error", {31'h0, sel_error}, 32'h0);
    rst_n = 1'b1;

    // Mid-cycle asynchronous reset
    drive_write(5, 32'hDEADBEEF); tick();
    drive_idle(); drive_read(5, 5); tick();
    check("pre_reset_r5", rd_data_a, 32'hDEADBEEF);
    drive_idle();
    #2 rst_n = 1'b0;
    model_clear();
    #1;
    check("async_reset_rd_data_a", rd_data_a, 32'h0);
    check("async_reset_rd_valid", {31'h0, rd_valid}, 32'h0);
    tick();
    rst_n = 1'b1;
    drive_read(5, 5); tick();
    check("post_reset_r5", rd_data_a, 32'h0);
    check("post_reset_valid", {31'h0, rd_valid}, 32'h1);

    // Write r1..r15, then read pairs (i, 16-i)
    drive_idle();
    for (int i = 1; i < 16; i++) begin
      drive_write(i, 32'h1000_0000 + i); tick();
    end
    drive_idle();
    for (int i = 1; i < 16; i++) begin
      drive_read(i, 16 - i); tick();
      check("pair_a", rd_data_a, 32'h1000_0000 + i);
      check("pair_b", rd_data_b, 32'h1000_0000 + (16 - i));
    end
    drive_idle();
    drive_write(0, 32'hFFFFFFFF); tick();
    drive_idle(); drive_read(0, 0); tick();
    check("r0_zero_a", rd_data_a, 32'h0);
    check("r0_zero_b", rd_data_b, 32'h0);

    // Bad selects
    drive_idle();
    wr_en = 1'b1; wr_sel = 16'h0000; wr_data = 32'hA5A5A5A5; tick();
    check("bad_sel_zero_err", {31'h0, sel_error}, 32'h1);
    wr_sel = 16'h0006; tick();
    check("bad_sel_multi_err", {31'h0, sel_error}, 32'h1);
    drive_idle(); drive_read(1, 2); tick();
    check("bad_sel_err_clear", {31'h0, sel_error}, 32'h0);
    check("bad_sel_r1", rd_data_a, 32'h1000_0001);
    check("bad_sel_r2", rd_data_b, 32'h1000_0002);

    // Same-edge write/read conflict
    drive_idle(); drive_write(7, 32'h11111111); tick();
    drive_read(7, 7); drive_write(7, 32'h22222222); tick();
`ifdef REGFILE_BYPASS_EN
    conflict_exp = 32'h22222222;
`else
    conflict_exp = 32'h11111111;
`endif
    check("conflict_a", rd_data_a, conflict_exp);
    check("conflict_b", rd_data_b, conflict_exp);
    drive_idle(); drive_read(7, 7); tick();
    check("conflict_after", rd_data_a, 32'h22222222);

    // Read hold
    drive_idle(); drive_write(3, 32'h33); tick();
    drive_idle(); drive_read(3, 3); tick();
    check("hold_first", rd_data_a, 32'h33);
    drive_idle(); drive_write(3, 32'h44); tick();
    check("hold_data", rd_data_a, 32'h33);
    check("hold_valid", {31'h0, rd_valid}, 32'h0);

    // Randomized traffic
    for (int c = 0; c < 400; c++) begin
      wr_en = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 5) == 0) wr_sel = 16'($urandom);
      else wr_sel = 16'h1 << $urandom_range(0, 15);
      wr_data = $urandom;
      rd_en = ($urandom_range(0, 3) != 0);
      rd_addr_a = 4'($urandom_range(0, 15));
      rd_addr_b = ($urandom_range(0, 3) == 0) ? rd_addr_a : 4'($urandom_range(0, 15));
      if (c == 200) begin
        #2 rst_n = 1'b0;
        model_clear();
        #1 rst_n = 1'b1;
      end
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
